// File: rtl/kgp_fetch_pkg.sv
// kgp_fetch_pkg: shared state encoding, default widths and queue entry type for instruction fetch
package kgp_fetch_pkg;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} fetch_state_e;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small instruction FIFO holding fetched {addr, data} pairs with flush
module fetch_queue
  import kgp_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  fetch_entry_t              din,
  output fetch_entry_t              dout,
  output logic                      valid,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t      mem [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign valid = count != '0;
  // pointers wrap naturally because QDEPTH is a power of two; flush outranks push/pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues PC addresses to instruction memory and queues returned words for decode
module instr_fetch_unit
  import kgp_fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              misalign_err
);
  localparam int CW = $clog2(QDEPTH) + 1;
  fetch_state_e      state;
  logic [ADDR_W-1:0] addr_q;
  logic              started, accept, push, pop;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  assign pc_ready      = started && state == S_IDLE && count < CW'(QDEPTH) && !misalign_err && !flush;
  assign accept        = pc_valid && pc_ready;
  assign mem_req_valid = state == S_REQ && !flush;
  assign mem_req_addr  = addr_q;
  assign push          = state == S_WAIT && mem_rsp_valid && !flush;
  assign pop           = instr_valid && instr_ready;
  assign instr         = head.data;
  assign instr_pc      = head.addr;
  // one outstanding request; flush withdraws a pending request and drains an in-flight response
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      started      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        misalign_err <= 1'b0;
        state        <= ((state == S_WAIT || state == S_DROP) && !mem_rsp_valid) ? S_DROP : S_IDLE;
      end else
        case (state)
          S_IDLE: if (accept) begin
            if (pc_in[1:0] != 2'b00) misalign_err <= 1'b1;
            else begin
              addr_q <= pc_in;
              state  <= S_REQ;
            end
          end
          S_REQ:  if (mem_req_ready) state <= S_WAIT;
          S_WAIT: if (mem_rsp_valid) state <= S_IDLE;
          S_DROP: if (mem_rsp_valid) state <= S_IDLE;
        endcase
    end
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{addr: addr_q, data: mem_rsp_data}),
    .dout  (head),
    .valid (instr_valid),
    .count (count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch handshake, queueing, flush and reset behaviour
module tb_instr_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_in = '0, mem_req_addr, mem_rsp_data = '0, instr, instr_pc;
  logic        pc_valid = 1'b0, pc_ready, flush = 1'b0, mem_req_valid, mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0, instr_valid, instr_ready = 1'b0, misalign_err;
  int          vectors = 0, errs = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc_in = a; pc_valid = 1'b1; mem_req_ready = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = d;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_instr", instr, 0);
    tick(); tick();
    chk("rst_hold_pc_ready", pc_ready, 0);
    rst = 1'b1;
    settle();
    chk("release_pc_ready_pre_edge", pc_ready, 0);
    tick();
    chk("release_pc_ready", pc_ready, 1);

    pc_in = 32'd45; pc_valid = 1'b1;
    tick();
    chk("mis_err_set", misalign_err, 1);
    chk("mis_no_req", mem_req_valid, 0);
    chk("mis_pc_ready", pc_ready, 0);
    tick();
    chk("mis_sticky", misalign_err, 1);
    chk("mis_still_no_req", mem_req_valid, 0);
    flush = 1'b1;
    settle();
    chk("mis_flush_pc_ready", pc_ready, 0);
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    settle();
    chk("mis_cleared", misalign_err, 0);
    chk("mis_pc_ready_back", pc_ready, 1);

    pc_in = 32'h40; pc_valid = 1'b1; mem_req_ready = 1'b1;
    tick();
    pc_valid = 1'b0;
    settle();
    chk("f1_req_valid", mem_req_valid, 1);
    chk("f1_req_addr", mem_req_addr, 32'h40);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A1B2C3;
    settle();
    chk("f1_not_yet_valid", instr_valid, 0);
    chk("f1_wait_no_req", mem_req_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("f1_instr_valid", instr_valid, 1);
    chk("f1_instr", instr, 32'h00A1B2C3);
    chk("f1_instr_pc", instr_pc, 32'h40);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    settle();
    chk("f1_popped", instr_valid, 0);

    fetch(32'h00, 32'h11);
    chk("q1_pc_ready", pc_ready, 1);
    fetch(32'h04, 32'h22);
    chk("qfull_pc_ready", pc_ready, 0);
    chk("qfull_head_pc", instr_pc, 32'h00);
    chk("qfull_head", instr, 32'h11);
    pc_in = 32'h08; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    settle();
    chk("qfull_no_accept", mem_req_valid, 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    settle();
    chk("qpop_head_pc", instr_pc, 32'h04);
    chk("qpop_head", instr, 32'h22);
    chk("qpop_pc_ready", pc_ready, 1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    settle();
    chk("q_drained", instr_valid, 0);

    mem_req_ready = 1'b0; pc_in = 32'h100; pc_valid = 1'b1;
    tick();
    pc_in = 32'h200;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, 32'h100);
      chk("stall_pc_ready", pc_ready, 0);
      tick();
    end
    pc_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h33;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("stall_instr_pc", instr_pc, 32'h100);
    chk("stall_instr", instr, 32'h33);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    pc_in = 32'h60; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    chk("wflush_pc_ready", pc_ready, 0);
    tick();
    flush = 1'b0; pc_in = 32'h80; pc_valid = 1'b1;
    settle();
    chk("drop_pc_ready", pc_ready, 0);
    tick();
    pc_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("drop_instr_valid", instr_valid, 0);
    chk("drop_pc_ready_back", pc_ready, 1);
    chk("drop_no_req", mem_req_valid, 0);
    fetch(32'h80, 32'h44);
    chk("after_drop_pc", instr_pc, 32'h80);
    chk("after_drop_instr", instr, 32'h44);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    pc_in = 32'h90; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    settle();
    chk("rflush_req_withdrawn", mem_req_valid, 0);
    tick();
    flush = 1'b0;
    settle();
    chk("rflush_idle_ready", pc_ready, 1);
    chk("rflush_no_req", mem_req_valid, 0);

    fetch(32'h10, 32'h55);
    chk("prerst_queued", instr_valid, 1);
    pc_in = 32'hC0; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_pc_ready", pc_ready, 0);
    chk("mrst_req_valid", mem_req_valid, 0);
    chk("mrst_req_addr", mem_req_addr, 0);
    chk("mrst_instr_valid", instr_valid, 0);
    chk("mrst_instr", instr, 0);
    chk("mrst_instr_pc", instr_pc, 0);
    tick();
    rst = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h66;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("late_rsp_ignored", instr_valid, 0);
    chk("late_rsp_pc_ready", pc_ready, 1);
    chk("late_rsp_no_req", mem_req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
